pong_game_ctrl: RTL and testbench

//  Match sequencer for the pong datapath. It sits between the vga timing block and the

---
 rtl/pong_pkg.sv | 21 ++
 rtl/pong_sync_edge.sv | 54 +++++
 rtl/pong_game_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller.
//  - state_t      : match sequencer states
//  - SERVE_LEFT   : serve_dir value for a serve toward the left player
//  - SERVE_RIGHT  : serve_dir value for a serve toward the right player
//  - DEF_WIN_SCORE: default number of points needed to win a match
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    localparam int DEF_WIN_SCORE = 7;

endpackage : pong_pkg

// File: rtl/pong_sync_edge.sv
// Optional 2-FF synchroniser followed by a single-edge detector.
//  clk    in  system clock
//  reset  in  asynchronous, active-low reset
//  din    in  raw input level
//  pulse  out 1-cycle combinational pulse on the selected edge of the
//             (synchronised or once-registered) input
// Parameters:
//  SYNC       1 = two synchroniser flops, 0 = a single register stage
//  RISE       1 = detect 0->1, 0 = detect 1->0
//  IDLE_LEVEL level all flops take in reset, so no edge is seen on release
module pong_sync_edge #(
    parameter bit   SYNC       = 1'b1,
    parameter bit   RISE       = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic cur;
    logic prev;

    generate
        if (SYNC) begin : g_sync
            logic meta;
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its source.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    meta <= IDLE_LEVEL;
                    cur  <= IDLE_LEVEL;
                end else begin
                    meta <= din;
                    cur  <= meta;
                end
            end
        end else begin : g_nosync
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) cur <= IDLE_LEVEL;
                else        cur <= din;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev <= IDLE_LEVEL;
        else        prev <= cur;
    end

    assign pulse = RISE ? (cur & ~prev) : (~cur & prev);

endmodule : pong_sync_edge

// File: rtl/pong_game_ctrl.sv
// Match sequencer for the pong datapath: holds the ball at centre before a
// serve, enables play, freezes the field after a point, keeps both scores and
// declares the winner. All timing is counted in frames (vsync falling edges).
//  clk         in  system clock
//  reset       in  asynchronous, active-low reset
//  vsync       in  vga vsync (active-low); frame tick derived from its fall
//  start       in  raw start button, synchronised internally
//  miss_l      in  1-cycle pulse: ball passed the left paddle
//  miss_r      in  1-cycle pulse: ball passed the right paddle
//  ball_reset  out 1 = ball held at centre
//  play_en     out 1 = ball and paddles may move
//  serve_dir   out 0 = serve toward left, 1 = toward right
//  score_l     out left player score
//  score_r     out right player score
//  game_over   out 1 while the match is over
//  winner      out 0 = left, 1 = right; valid while game_over=1
//  frame_tick  out 1-cycle pulse per frame
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SCORE_W      = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int FRAME_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               start,
    input  logic               miss_l,
    input  logic               miss_r,
    output logic               ball_reset,
    output logic               play_en,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic               winner,
    output logic               frame_tick
);

    localparam logic [SCORE_W-1:0] WIN_CNT   = SCORE_W'(WIN_SCORE);
    localparam logic [FRAME_W-1:0] SERVE_CNT = FRAME_W'(SERVE_FRAMES);
    localparam logic [FRAME_W-1:0] POINT_CNT = FRAME_W'(POINT_FRAMES);
    localparam logic [FRAME_W-1:0] LAST_CNT  = FRAME_W'(1);

    logic vsync_fall;
    logic start_rise;

    // vsync already comes from the same clock domain, so only one register
    // stage is needed before the edge detector.
    pong_sync_edge #(.SYNC(1'b0), .RISE(1'b0), .IDLE_LEVEL(1'b1)) u_vsync_edge (
        .clk   (clk),
        .reset (reset),
        .din   (vsync),
        .pulse (vsync_fall)
    );

    pong_sync_edge #(.SYNC(1'b1), .RISE(1'b1), .IDLE_LEVEL(1'b0)) u_start_edge (
        .clk   (clk),
        .reset (reset),
        .din   (start),
        .pulse (start_rise)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) frame_tick <= 1'b0;
        else        frame_tick <= vsync_fall;
    end

    state_t               state, state_nxt;
    logic [FRAME_W-1:0]   cnt, cnt_nxt;
    logic [SCORE_W-1:0]   score_l_nxt, score_r_nxt;
    logic                 serve_dir_nxt;
    logic                 ball_reset_nxt, play_en_nxt, game_over_nxt, winner_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            score_l    <= '0;
            score_r    <= '0;
            serve_dir  <= SERVE_RIGHT;
            ball_reset <= 1'b1;
            play_en    <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            score_l    <= score_l_nxt;
            score_r    <= score_r_nxt;
            serve_dir  <= serve_dir_nxt;
            ball_reset <= ball_reset_nxt;
            play_en    <= play_en_nxt;
            game_over  <= game_over_nxt;
            winner     <= winner_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_nxt     = state;
        cnt_nxt       = cnt;
        score_l_nxt   = score_l;
        score_r_nxt   = score_r;
        serve_dir_nxt = serve_dir;

        unique case (state)
            ST_IDLE: begin
                if (start_rise) begin
                    state_nxt = ST_SERVE;
                    cnt_nxt   = SERVE_CNT;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    cnt_nxt = cnt - LAST_CNT;
                    if (cnt == LAST_CNT) state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A simultaneous double miss is a replay: no score, but the
                // serve swaps so the same player doesn't always receive it.
                if (miss_l && miss_r) begin
                    serve_dir_nxt = ~serve_dir;
                end else if (miss_l) begin
                    score_r_nxt   = score_r + 1'b1;
                    serve_dir_nxt = SERVE_LEFT;
                end else if (miss_r) begin
                    score_l_nxt   = score_l + 1'b1;
                    serve_dir_nxt = SERVE_RIGHT;
                end
                if (miss_l || miss_r) begin
                    state_nxt = ST_POINT;
                    cnt_nxt   = POINT_CNT;
                end
            end
            ST_POINT: begin
                if (frame_tick) begin
                    cnt_nxt = cnt - LAST_CNT;
                    if (cnt == LAST_CNT) begin
                        if (score_l == WIN_CNT || score_r == WIN_CNT) begin
                            state_nxt = ST_OVER;
                        end else begin
                            state_nxt = ST_SERVE;
                            cnt_nxt   = SERVE_CNT;
                        end
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    score_l_nxt   = '0;
                    score_r_nxt   = '0;
                    serve_dir_nxt = SERVE_RIGHT;
                    state_nxt     = ST_SERVE;
                    cnt_nxt       = SERVE_CNT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in the
        // same edge as the state change.
        ball_reset_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_SERVE) ||
                         (state_nxt == ST_OVER);
        play_en_nxt    = (state_nxt == ST_PLAY);
        game_over_nxt  = (state_nxt == ST_OVER);
        winner_nxt     = (state_nxt == ST_OVER) && (score_r_nxt == WIN_CNT);
    end

endmodule : pong_game_ctrl

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with short frame counts. Expected output
// snapshots are queued as each step is driven and compared once it settles.
module tb_pong_game_ctrl;

    localparam int SCORE_W = 4;

    typedef struct packed {
        logic               ball_reset;
        logic               play_en;
        logic               serve_dir;
        logic [SCORE_W-1:0] score_l;
        logic [SCORE_W-1:0] score_r;
        logic               game_over;
        logic               winner;
    } snap_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               vsync = 1'b1;
    logic               start = 1'b0;
    logic               miss_l = 1'b0;
    logic               miss_r = 1'b0;
    logic               ball_reset, play_en, serve_dir, game_over, winner, frame_tick;
    logic [SCORE_W-1:0] score_l, score_r;

    int checks = 0;
    int errors = 0;

    snap_t exp_q[$];
    string tag_q[$];

    pong_game_ctrl #(
        .WIN_SCORE   (4),
        .SCORE_W     (SCORE_W),
        .SERVE_FRAMES(3),
        .POINT_FRAMES(2),
        .FRAME_W     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .start      (start),
        .miss_l     (miss_l),
        .miss_r     (miss_r),
        .ball_reset (ball_reset),
        .play_en    (play_en),
        .serve_dir  (serve_dir),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .winner     (winner),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(input logic br, input logic pe, input logic sd,
                                 input int sl, input int sr,
                                 input logic go, input logic wn);
        mk = '{br, pe, sd, SCORE_W'(sl), SCORE_W'(sr), go, wn};
    endfunction

    task automatic expect_snap(input string tag, input snap_t s);
        exp_q.push_back(s);
        tag_q.push_back(tag);
    endtask

    task automatic compare_snap();
        snap_t obs, e;
        string t;
        obs = '{ball_reset, play_en, serve_dir, score_l, score_r, game_over, winner};
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed br=%b pe=%b sd=%b sl=%0d sr=%0d go=%b wn=%b expected br=%b pe=%b sd=%b sl=%0d sr=%0d go=%b wn=%b",
                   t, obs.ball_reset, obs.play_en, obs.serve_dir, obs.score_l, obs.score_r,
                   obs.game_over, obs.winner, e.ball_reset, e.play_en, e.serve_dir,
                   e.score_l, e.score_r, e.game_over, e.winner);
        end
    endtask

    task automatic check_tick(input string tag, input logic expv);
        checks++;
        assert (frame_tick === expv) else begin
            errors++;
            $error("FAIL %s: observed frame_tick=%b expected %b", tag, frame_tick, expv);
        end
    endtask

    // One vsync low pulse; returns after the FSM has reacted to the tick.
    task automatic frame();
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    // Two synchroniser flops plus one FSM edge before the state changes.
    task automatic press_start();
        start = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic release_start();
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        miss_l = l;
        miss_r = r;
        @(negedge clk);
        miss_l = 1'b0;
        miss_r = 1'b0;
    endtask

    snap_t rst_snap;

    initial begin
        rst_snap = mk(1, 0, 1, 0, 0, 0, 0);

        // 1. reset values, idle state, frame tick timing
        repeat (2) @(negedge clk);
        expect_snap("reset_values", rst_snap);
        compare_snap();
        check_tick("reset_tick", 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        expect_snap("idle_after_release", rst_snap);
        compare_snap();

        vsync = 1'b0;
        @(negedge clk);
        check_tick("tick_lat1", 1'b0);
        @(negedge clk);
        check_tick("tick_lat2", 1'b1);
        @(negedge clk);
        check_tick("tick_width", 1'b0);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        expect_snap("idle_ignores_tick", rst_snap);
        compare_snap();

        // 2. start -> SERVE for three frames -> PLAY, start held high throughout
        expect_snap("serve_entry", mk(1, 0, 1, 0, 0, 0, 0));
        press_start();
        compare_snap();
        expect_snap("serve_after_2_frames", mk(1, 0, 1, 0, 0, 0, 0));
        frames(2);
        compare_snap();
        expect_snap("play_after_3_frames", mk(0, 1, 1, 0, 0, 0, 0));
        frame();
        compare_snap();
        expect_snap("play_start_held", mk(0, 1, 1, 0, 0, 0, 0));
        frames(2);
        compare_snap();
        release_start();

        // 3. miss_r scores left, POINT freeze, then a miss in SERVE is ignored
        expect_snap("miss_r_point", mk(0, 0, 1, 1, 0, 0, 0));
        pulse_miss(1'b0, 1'b1);
        compare_snap();
        expect_snap("point_before_expiry", mk(0, 0, 1, 1, 0, 0, 0));
        frame();
        compare_snap();
        expect_snap("point_to_serve", mk(1, 0, 1, 1, 0, 0, 0));
        frame();
        compare_snap();
        expect_snap("miss_l_in_serve", mk(1, 0, 1, 1, 0, 0, 0));
        pulse_miss(1'b1, 1'b0);
        compare_snap();
        expect_snap("serve_to_play", mk(0, 1, 1, 1, 0, 0, 0));
        frames(3);
        compare_snap();

        // 4. simultaneous misses: no score, serve toggles, POINT
        expect_snap("double_miss", mk(0, 0, 0, 1, 0, 0, 0));
        pulse_miss(1'b1, 1'b1);
        compare_snap();
        frames(5);

        // bring score_l to 3 in PLAY
        expect_snap("miss_r_2", mk(0, 0, 1, 2, 0, 0, 0));
        pulse_miss(1'b0, 1'b1);
        compare_snap();
        frames(5);
        pulse_miss(1'b0, 1'b1);
        frames(5);
        expect_snap("play_score_l_3", mk(0, 1, 1, 3, 0, 0, 0));
        compare_snap();

        // 6. asynchronous reset mid-PLAY
        reset = 1'b0;
        #1;
        expect_snap("async_reset", rst_snap);
        compare_snap();
        check_tick("async_reset_tick", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        frames(4);
        expect_snap("idle_needs_start", rst_snap);
        compare_snap();
        press_start();
        release_start();
        expect_snap("replay_to_play", mk(0, 1, 1, 0, 0, 0, 0));
        frames(3);
        compare_snap();

        // 5. right player reaches WIN_SCORE=4 -> OVER, winner right
        for (int i = 1; i <= 4; i++) begin
            expect_snap($sformatf("miss_l_%0d", i), mk(0, 0, 0, 0, i, 0, 0));
            pulse_miss(1'b1, 1'b0);
            compare_snap();
            frames(2);
            if (i < 4) frames(3);
        end
        expect_snap("game_over", mk(1, 0, 0, 0, 4, 1, 1));
        compare_snap();
        expect_snap("miss_in_over", mk(1, 0, 0, 0, 4, 1, 1));
        pulse_miss(1'b0, 1'b1);
        frames(3);
        compare_snap();
        expect_snap("restart_from_over", mk(1, 0, 1, 0, 0, 0, 0));
        press_start();
        compare_snap();
        release_start();

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule : tb_pong_game_ctrl
